// File: rtl/bouncing_box_pkg.sv
// Shared constants and types for the bouncing-box pixel source.
package bouncing_box_pkg;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    localparam logic [7:0] CHK_HI = 8'hC0;
    localparam logic [7:0] CHK_LO = 8'h40;

endpackage

// File: rtl/bouncing_box_gen_box_axis.sv
// One axis of the bouncing square: position, direction and edge bounce.
module box_axis
    import bouncing_box_pkg::*;
#(
    parameter int unsigned LIMIT = 640,
    parameter int unsigned SIZE  = 32,
    parameter int unsigned STEP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       run,
    output logic [9:0] pos,
    output logic       dir
);

    localparam logic [9:0]  MAX_POS  = 10'(LIMIT - SIZE);
    localparam logic [10:0] FAR_EDGE = 11'(SIZE + STEP);

    dir_t       dir_q;
    logic [10:0] pos_w;

    assign pos_w = {1'b0, pos};
    assign dir   = dir_q;

    // An overshoot clamps to the edge and reverses; the step is not carried over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos   <= '0;
            dir_q <= DIR_POS;
        end else if (tick && run) begin
            case (dir_q)
                DIR_POS: begin
                    if (pos_w + FAR_EDGE > 11'(LIMIT)) begin
                        pos   <= MAX_POS;
                        dir_q <= DIR_NEG;
                    end else begin
                        pos <= pos + 10'(STEP);
                    end
                end
                default: begin
                    if (pos_w < 11'(STEP)) begin
                        pos   <= '0;
                        dir_q <= DIR_POS;
                    end else begin
                        pos <= pos - 10'(STEP);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/bouncing_box_gen.sv
// Colour-bar background with a bouncing square; pixel output registered, 1 clk latency.
// Define CHECKER_BG_EN to replace the bars with a scrolling checkerboard.
module bouncing_box_gen
    import bouncing_box_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned BOX_SIZE      = 32,
    parameter int unsigned STEP_X        = 2,
    parameter int unsigned STEP_Y        = 1,
    parameter logic [23:0] BOX_COLOR     = 24'hFFFFFF,
    parameter bit          VSYNC_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       vsync,
    input  logic       run,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] frame_cnt
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic        vs_q;
    logic        frame_tick;
    logic [9:0]  box_x, box_y;
    logic        dir_x, dir_y;
    logic        unused_dir;
    logic [10:0] x_w, y_w, bx_w, by_w;
    logic        in_area, in_box;
    logic [23:0] bg;

    // Normalise both samples to active-high so the tick is a plain rising edge.
    assign frame_tick = (vsync ^ VSYNC_ACT_LOW) & ~(vs_q ^ VSYNC_ACT_LOW);
    assign unused_dir = dir_x ^ dir_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q      <= VSYNC_ACT_LOW;
            frame_cnt <= '0;
        end else begin
            vs_q <= vsync;
            if (frame_tick)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    box_axis #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP_X)) u_axis_x (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .run  (run),
        .pos  (box_x),
        .dir  (dir_x)
    );

    box_axis #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP_Y)) u_axis_y (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick),
        .run  (run),
        .pos  (box_y),
        .dir  (dir_y)
    );

    assign x_w  = {1'b0, x};
    assign y_w  = {1'b0, y};
    assign bx_w = {1'b0, box_x};
    assign by_w = {1'b0, box_y};

    always_comb begin
        in_area = (x_w < 11'(H_ACTIVE)) && (y_w < 11'(V_ACTIVE));
        in_box  = (x_w >= bx_w) && (x_w < bx_w + 11'(BOX_SIZE)) &&
                  (y_w >= by_w) && (y_w < by_w + 11'(BOX_SIZE));
    end

`ifdef CHECKER_BG_EN
    logic       scroll_b5;
    logic [4:0] unused_scroll_lo;

    // Only bit 5 of x+frame_cnt matters, so a 6-bit add is enough.
    assign {scroll_b5, unused_scroll_lo} = x[5:0] + frame_cnt[5:0];

    always_comb begin
        bg = (scroll_b5 ^ y[5]) ? {CHK_HI, CHK_HI, CHK_HI} : {CHK_LO, CHK_LO, CHK_LO};
    end
`else
    always_comb begin
        bg = COL_BLACK;
        if      (x_w < 11'(BAR_W * 1)) bg = COL_WHITE;
        else if (x_w < 11'(BAR_W * 2)) bg = COL_YELLOW;
        else if (x_w < 11'(BAR_W * 3)) bg = COL_CYAN;
        else if (x_w < 11'(BAR_W * 4)) bg = COL_GREEN;
        else if (x_w < 11'(BAR_W * 5)) bg = COL_MAGENTA;
        else if (x_w < 11'(BAR_W * 6)) bg = COL_RED;
        else if (x_w < 11'(BAR_W * 7)) bg = COL_BLUE;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {red, green, blue} <= '0;
        end else if (!in_area) begin
            {red, green, blue} <= '0;
        end else if (in_box) begin
            {red, green, blue} <= BOX_COLOR;
        end else begin
            {red, green, blue} <= bg;
        end
    end

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Randomised self-checking bench for bouncing_box_gen against a behavioural model.
module tb_bouncing_box_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       vsync;
    logic       run;
    logic [7:0] red, green, blue, frame_cnt;

    int checks = 0;
    int errors = 0;

    int m_bx, m_by, m_dx, m_dy, m_fc;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    bouncing_box_gen dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .vsync     (vsync),
        .run       (run),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_fc = 0;
    endtask

    function automatic void axis_step(inout int p, inout int d, input int lim, input int step);
        if (d > 0) begin
            if (p + 32 + step > lim) begin p = lim - 32; d = -1; end
            else p = p + step;
        end else begin
            if (p < step) begin p = 0; d = 1; end
            else p = p - step;
        end
    endfunction

    task automatic model_tick(input bit r);
        m_fc = (m_fc + 1) % 256;
        if (r) begin
            axis_step(m_bx, m_dx, 640, 2);
            axis_step(m_by, m_dy, 480, 1);
        end
    endtask

    function automatic logic [23:0] model_rgb(input int px, input int py);
        if (px >= 640 || py >= 480) return 24'h0;
        if (px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32) return 24'hFFFFFF;
`ifdef CHECKER_BG_EN
        if ((((px + m_fc) / 32) ^ (py / 32)) % 2 == 1) return 24'hC0C0C0;
        return 24'h404040;
`else
        return BARS[px / 80];
`endif
    endfunction

    task automatic pixel(input int px, input int py, input string tag);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        @(posedge clk);
        #1 check(tag, {8'h0, red, green, blue}, {8'h0, model_rgb(px, py)});
    endtask

    task automatic do_tick();
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        model_tick(run);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_bx"}, 32'(dut.u_axis_x.pos), 32'(m_bx));
        check({tag, "_by"}, 32'(dut.u_axis_y.pos), 32'(m_by));
        check({tag, "_dx"}, 32'(dut.u_axis_x.dir), 32'(m_dx < 0));
        check({tag, "_dy"}, 32'(dut.u_axis_y.dir), 32'(m_dy < 0));
        check({tag, "_fc"}, 32'(frame_cnt), 32'(m_fc));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; vsync = 1'b1; run = 1'b1; x = '0; y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rgb", {8'h0, red, green, blue}, 32'h0);
        check("rst_fc", 32'(frame_cnt), 32'h0);
        rst = 1'b1;

        pixel(5, 5, "box_origin");
        pixel(32, 5, "bar_after_box");

        do_tick();
        check("tick1_bx", 32'(dut.u_axis_x.pos), 32'd2);
        check("tick1_by", 32'(dut.u_axis_y.pos), 32'd1);
        check("tick1_fc", 32'(frame_cnt), 32'd1);

        @(negedge clk);
        vsync = 1'b0;
        repeat (100) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        model_tick(run);
        check("hold_fc", 32'(frame_cnt), 32'd2);
        check_state("hold");

        pixel(0, 10, "row_x0");
        pixel(80, 10, "row_x80");
        pixel(639, 10, "row_x639");
        pixel(640, 10, "row_x640");
`ifndef CHECKER_BG_EN
        check("bar_const_x80", {8'h0, model_rgb(80, 10)}, 32'hFFFF00);
`endif

        run = 1'b0;
        repeat (5) do_tick();
        check("frozen_bx", 32'(dut.u_axis_x.pos), 32'd4);
        check("frozen_by", 32'(dut.u_axis_y.pos), 32'd2);
        check("frozen_fc", 32'(frame_cnt), 32'd7);

        for (int r = 0; r < 40; r++) begin
            run = 1'($urandom_range(0, 3) != 0);
            do_tick();
            check_state("rnd");
            for (int k = 0; k < 4; k++)
                pixel($urandom_range(0, 719), $urandom_range(0, 519), "rnd_px");
            pixel(m_bx + $urandom_range(0, 31), m_by + $urandom_range(0, 31), "rnd_box");
        end

        pixel(m_bx + 3, m_by + 3, "pre_rst_box");
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("midrst_rgb", {8'h0, red, green, blue}, 32'h0);
        check("midrst_fc", 32'(frame_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("postrst_bx", 32'(dut.u_axis_x.pos), 32'd0);
        check("postrst_by", 32'(dut.u_axis_y.pos), 32'd0);
        pixel(10, 10, "postrst_box");

        run = 1'b1;
        apply_reset();
        repeat (256) do_tick();
        check_state("t256");
        pixel(0, 0, "wrap_px00");
        pixel(32, 0, "wrap_px32");
`ifdef CHECKER_BG_EN
        check("chk_const_00", {8'h0, model_rgb(0, 0)}, 32'h404040);
`endif
        repeat (32) do_tick();
        pixel(0, 0, "scroll_px00");
        repeat (16) do_tick();
        check("t304_bx", 32'(dut.u_axis_x.pos), 32'd608);
        check_state("t304");
        do_tick();
        check("t305_bx", 32'(dut.u_axis_x.pos), 32'd608);
        check("t305_dx", 32'(dut.u_axis_x.dir), 32'd1);
        do_tick();
        check("t306_bx", 32'(dut.u_axis_x.pos), 32'd606);
        check_state("t306");
        repeat (142) do_tick();
        check("t448_by", 32'(dut.u_axis_y.pos), 32'd448);
        check_state("t448");
        do_tick();
        check("t449_by", 32'(dut.u_axis_y.pos), 32'd448);
        check("t449_dy", 32'(dut.u_axis_y.dir), 32'd1);
        do_tick();
        check("t450_by", 32'(dut.u_axis_y.pos), 32'd447);
        check_state("t450");
        pixel(m_bx, m_by, "corner_box");
        pixel(m_bx + 32, m_by, "right_of_box");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
